mult_add_reconstruct: RTL and testbench

- Pipelined inverse of the divider/modulo block: rebuilds dividend = quotient*divisor + remainder (mode 0), or returns the plain product quotient*divisor (mode 1).
- Sits after the divider as a self-check and recomposition stage.
- Same valid_in/valid_out streaming style as the divider: one new operand set per clock, fixed latency, no backpressure.

---
 rtl/mult_add_reconstruct.sv | 118 +++++++++++
 tb/tb_mult_add_reconstruct.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_add_reconstruct.sv
// +--------------------------------------------------------------------------+
// | mult_add_reconstruct: pipelined quotient*divisor(+remainder) recompose   |
// | Optional DIV_RECON_CHECK_EN adds check_dividend / mismatch.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mult_add_reconstruct #(
  parameter int QUOT_W         = 32,
  parameter int DIVISOR_W      = 16,
  parameter int BITS_PER_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 mode,
  input  logic [QUOT_W-1:0]    quotient,
  input  logic [DIVISOR_W-1:0] divisor,
  input  logic [DIVISOR_W-1:0] remainder,
`ifdef DIV_RECON_CHECK_EN
  input  logic [QUOT_W-1:0]    check_dividend,
  output logic                 mismatch,
`endif
  output logic [QUOT_W-1:0]    result,
  output logic                 overflow,
  output logic                 valid_out
);

  localparam int S     = DIVISOR_W / BITS_PER_STAGE;
  localparam int ACC_W = QUOT_W + DIVISOR_W;

  if ((DIVISOR_W % BITS_PER_STAGE) != 0) begin : g_geom_err
    $error("DIVISOR_W must be divisible by BITS_PER_STAGE");
  end

  logic [QUOT_W-1:0]    quot_q [0:S-1];
  logic [DIVISOR_W-1:0] div_q  [0:S-1];
  logic [ACC_W-1:0]     acc_q  [0:S];
  logic                 vld_q  [0:S];
  logic [ACC_W-1:0]     fold_acc_d [0:S-1];

  logic [QUOT_W-1:0]    result_q;
  logic                 overflow_q;
  logic                 valid_out_q;
  logic [QUOT_W-1:0]    result_d;
  logic                 overflow_d;

  // Each stage folds its divisor slice as one partial product of quotient.
  for (genvar k = 0; k < S; k++) begin : g_fold
    localparam int LSB = k * BITS_PER_STAGE;
    logic [BITS_PER_STAGE-1:0] slice;
    assign slice         = div_q[k][LSB +: BITS_PER_STAGE];
    assign fold_acc_d[k] = acc_q[k] +
                           ((ACC_W'(quot_q[k]) * ACC_W'(slice)) << LSB);
  end

  assign result_d   = acc_q[S][QUOT_W-1:0];
  assign overflow_d = |acc_q[S][ACC_W-1:QUOT_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < S; k++) begin
        quot_q[k] <= '0;
        div_q[k]  <= '0;
      end
      for (int k = 0; k <= S; k++) begin
        acc_q[k] <= '0;
        vld_q[k] <= 1'b0;
      end
      result_q    <= '0;
      overflow_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      quot_q[0] <= quotient;
      div_q[0]  <= divisor;
      acc_q[0]  <= mode ? '0 : {{QUOT_W{1'b0}}, remainder};
      vld_q[0]  <= valid_in;
      for (int k = 0; k < S - 1; k++) begin
        quot_q[k+1] <= quot_q[k];
        div_q[k+1]  <= div_q[k];
      end
      for (int k = 0; k < S; k++) begin
        acc_q[k+1] <= fold_acc_d[k];
        vld_q[k+1] <= vld_q[k];
      end
      valid_out_q <= vld_q[S];
      if (vld_q[S]) begin
        result_q   <= result_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_out_q;

`ifdef DIV_RECON_CHECK_EN
  logic [QUOT_W-1:0] chk_q [0:S];
  logic              mismatch_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= S; k++) chk_q[k] <= '0;
      mismatch_q <= 1'b0;
    end else begin
      chk_q[0] <= check_dividend;
      for (int k = 0; k < S; k++) chk_q[k+1] <= chk_q[k];
      if (vld_q[S]) mismatch_q <= overflow_d || (result_d != chk_q[S]);
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_add_reconstruct.sv
// +--------------------------------------------------------------------------+
// | tb_mult_add_reconstruct: directed vector bench for mult_add_reconstruct  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mult_add_reconstruct;

  localparam int LAT = 9;
  localparam int NV  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        mode;
  logic [31:0] quotient;
  logic [15:0] divisor;
  logic [15:0] remainder;
  logic [31:0] result;
  logic        overflow;
  logic        valid_out;
`ifdef DIV_RECON_CHECK_EN
  logic [31:0] check_dividend;
  logic        mismatch;
`endif

  mult_add_reconstruct #(
    .QUOT_W(32), .DIVISOR_W(16), .BITS_PER_STAGE(2)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mode(mode),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
`ifdef DIV_RECON_CHECK_EN
    .check_dividend(check_dividend), .mismatch(mismatch),
`endif
    .result(result), .overflow(overflow), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        m;
    logic [31:0] q;
    logic [15:0] d;
    logic [15:0] r;
    logic [31:0] er;
    logic        eo;
  } vec_t;

  vec_t tv [NV];
  int   n_applied = 0;
  int   n_fail    = 0;
  logic [31:0] last_r;
  logic        last_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [31:0] er, input logic eo);
    chk({nm, ".valid_out"}, 32'(valid_out), 32'(ev));
    chk({nm, ".result"},    result,         er);
    chk({nm, ".overflow"},  32'(overflow),  32'(eo));
  endtask

  task automatic drive(input logic v, input logic m, input logic [31:0] q,
                       input logic [15:0] d, input logic [15:0] r);
    valid_in  = v;
    mode      = m;
    quotient  = q;
    divisor   = d;
    remainder = r;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 32'd1234,       16'd100,    16'd56,     32'd123456,     1'b0};
    tv[1]  = '{1'b1, 1'b1, 32'd7,          16'd9,      16'd11,     32'd63,         1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'd5,          16'd3,      16'd2,      32'd17,         1'b0};
    tv[3]  = '{1'b1, 1'b1, 32'd0,          16'hFFFF,   16'd4,      32'd0,          1'b0};
    tv[4]  = '{1'b1, 1'b1, 32'hFFFFFFFF,   16'd2,      16'd0,      32'hFFFFFFFE,   1'b1};
    tv[5]  = '{1'b1, 1'b0, 32'h80000000,   16'd1,      16'hFFFF,   32'h8000FFFF,   1'b0};
    tv[6]  = '{1'b0, 1'b0, 32'd99,         16'd99,     16'd99,     32'd0,          1'b0};
    tv[7]  = '{1'b1, 1'b0, 32'd12345,      16'd0,      16'd5,      32'd5,          1'b0};
    tv[8]  = '{1'b1, 1'b1, 32'd12345,      16'd0,      16'd5,      32'd0,          1'b0};
    tv[9]  = '{1'b0, 1'b1, 32'd1,          16'd1,      16'd1,      32'd0,          1'b0};
    tv[10] = '{1'b1, 1'b0, 32'd0,          16'd77,     16'd999,    32'd999,        1'b0};
    tv[11] = '{1'b1, 1'b0, 32'hFFFFFFFF,   16'hFFFF,   16'hFFFF,   32'h00000000,   1'b1};
    tv[12] = '{1'b1, 1'b0, 32'd10,         16'd3,      16'd50,     32'd80,         1'b0};
    tv[13] = '{1'b1, 1'b1, 32'h00010000,   16'h8000,   16'd0,      32'h80000000,   1'b0};
    tv[14] = '{1'b1, 1'b1, 32'h00020000,   16'h8000,   16'd0,      32'h00000000,   1'b1};
    tv[15] = '{1'b1, 1'b1, 32'h12345678,   16'd3,      16'd0,      32'h369D0368,   1'b0};

    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
`ifdef DIV_RECON_CHECK_EN
    check_dividend = '0;
`endif
    #12;
    chk_out("reset", 1'b0, 32'd0, 1'b0);
`ifdef DIV_RECON_CHECK_EN
    chk("reset.mismatch", 32'(mismatch), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Streaming table: row c is driven at iteration c, appears at c+LAT+1.
    last_r = '0;
    last_o = 1'b0;
    for (int c = 0; c < NV + LAT + 1; c++) begin
      @(negedge clk);
      if (c >= LAT + 1) begin
        int i;
        i = c - LAT - 1;
        if (tv[i].v) begin
          last_r = tv[i].er;
          last_o = tv[i].eo;
        end
        chk_out($sformatf("vec%0d", i), tv[i].v, last_r, last_o);
      end else begin
        chk($sformatf("lat%0d.valid_out", c), 32'(valid_out), 32'd0);
      end
      if (c < NV) drive(tv[c].v, tv[c].m, tv[c].q, tv[c].d, tv[c].r);
      else        drive(1'b0, 1'b0, '0, '0, '0);
    end

    // Single operation: exact latency, then hold on the following bubble.
    for (int c = 0; c < 4; c++) @(negedge clk);
    drive(1'b1, 1'b0, 32'd1234, 16'd100, 16'd56);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b0, 32'hDEAD, 16'hBEEF, 16'h1111);
      if (c < 10)       chk($sformatf("single.c%0d.valid_out", c), 32'(valid_out), 32'd0);
      else if (c == 10) chk_out("single.out", 1'b1, 32'd123456, 1'b0);
      else              chk_out("single.hold", 1'b0, 32'd123456, 1'b0);
    end

    // Asynchronous reset mid-cycle with four operations in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'(i + 1), 16'd3, 16'd0);
    end
    @(posedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);
    #2 reset = 1'b0;
    #1 chk_out("async_rst", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk_out($sformatf("flush.c%0d", c), 1'b0, 32'd0, 1'b0);
    end
    drive(1'b1, 1'b0, 32'd9, 16'd9, 16'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b0, '0, '0, '0);
      if (c < 10) chk($sformatf("post_rst.c%0d.valid_out", c), 32'(valid_out), 32'd0);
      else        chk_out("post_rst.out", 1'b1, 32'd82, 1'b0);
    end

`ifdef DIV_RECON_CHECK_EN
    // Back-to-back check stream: match, off-by-one, overflow.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd1234, 16'd100, 16'd56);
    check_dividend = 32'd123456;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive(1'b1, 1'b0, 32'd1234, 16'd100, 16'd56);
        check_dividend = 32'd123457;
      end else if (c == 2) begin
        drive(1'b1, 1'b1, 32'hFFFFFFFF, 16'd2, 16'd0);
        check_dividend = 32'hFFFFFFFE;
      end else if (c == 3) begin
        drive(1'b0, 1'b0, '0, '0, '0);
        check_dividend = '0;
      end
      if (c == 10) begin
        chk_out("chk.match", 1'b1, 32'd123456, 1'b0);
        chk("chk.match.mismatch", 32'(mismatch), 32'd0);
      end else if (c == 11) begin
        chk_out("chk.diff", 1'b1, 32'd123456, 1'b0);
        chk("chk.diff.mismatch", 32'(mismatch), 32'd1);
      end else if (c == 12) begin
        chk_out("chk.ovf", 1'b1, 32'hFFFFFFFE, 1'b1);
        chk("chk.ovf.mismatch", 32'(mismatch), 32'd1);
      end
    end
    @(negedge clk);
    chk("chk.hold.mismatch", 32'(mismatch), 32'd1);
    chk("chk.hold.valid_out", 32'(valid_out), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
